dmem_responder: RTL and testbench

Multi-cycle data-memory responder on the far side of the CPU MEM-stage load/store interface. It accepts the read or write request the pipeline drives (`MemRead`/`MemWrite`, address, write data) and holds `stall_o` high while serving it. The pipeline therefore freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB until the access completes. It replaces the zero-latency data memory when modelling a realistic memory latency.

---
 rtl/dmem_responder.sv | 80 ++++++++
 tb/tb_dmem_responder.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder that stalls the pipeline for LATENCY+1 cycles per access.
//   clk_i      clock, rising edge
//   rst_i      synchronous active-low reset
//   MemRead_i  read request, held while stall_o is high
//   MemWrite_i write request, held while stall_o is high (wins when both are set)
//   addr_i     byte address, word index addr_i[AW+1:2]
//   data_i     write data
//   data_o     registered read data, held until the next completed read
//   stall_o    high while a request is outstanding
//   err_o      registered access error
// Optional feature: define DMEM_ADDR_CHECK_EN to flag misaligned/out-of-range addresses.
module dmem_responder #(
  parameter int DEPTH = 256,
  parameter int AW = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        stall_o,
  output logic        err_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt;
  logic op_wr, bad_q, err_q, req, addr_bad, commit;
  logic [AW-1:0] idx_q;
  logic [31:0] wdata_q;
  logic [31:0] mem [DEPTH];
`ifdef DMEM_ADDR_CHECK_EN
  assign addr_bad = (|addr_i[1:0]) | (|addr_i[31:AW+2]);
`else
  logic unused_addr;
  assign unused_addr = ^{addr_i[1:0], addr_i[31:AW+2]};
  assign addr_bad = 1'b0;
`endif
  assign req = MemRead_i | MemWrite_i;
  assign commit = (state == BUSY) && (cnt == 4'd0);
  assign err_o = err_q;
  always_comb begin
    stall_o = ((state == IDLE) && req) || (state == BUSY);
    state_nxt = (state == IDLE) ? (req ? BUSY : IDLE) :
                (state == BUSY) ? (commit ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= IDLE;
      cnt <= 4'd0;
      data_o <= 32'h0;
      err_q <= 1'b0;
      op_wr <= 1'b0;
      bad_q <= 1'b0;
      idx_q <= '0;
      wdata_q <= 32'h0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req) begin
        cnt <= 4'(LATENCY - 1);
        op_wr <= MemWrite_i;
        bad_q <= addr_bad;
        idx_q <= addr_i[AW+1:2];
        wdata_q <= data_i;
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (commit) begin
        err_q <= bad_q;
        if (!op_wr) data_o <= bad_q ? 32'h0 : mem[idx_q];
      end
    end
  end
  // Kept reset-free so the array maps onto plain RAM; reset still blocks a pending commit.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit && op_wr && !bad_q) mem[idx_q] <= wdata_q;
  end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plus randomized checks of dmem_responder against a transaction-level memory model.
module tb_dmem_responder;
  localparam int LAT = 2;
  logic clk = 0, rst_i = 0, MemRead_i = 0, MemWrite_i = 0;
  logic [31:0] addr_i = 0, data_i = 0, data_o, d1, d15;
  logic stall_o, err_o, stall1, stall15, e1, e15;
  int checks = 0, errors = 0;
  logic [31:0] model [256];
  logic [31:0] exp_data = 0;
  logic exp_err = 0;

  dmem_responder #(.DEPTH(256), .AW(8), .LATENCY(LAT)) dut (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o), .err_o(err_o));
  dmem_responder #(.DEPTH(256), .AW(8), .LATENCY(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(d1), .stall_o(stall1), .err_o(e1));
  dmem_responder #(.DEPTH(256), .AW(8), .LATENCY(15)) dut15 (
    .clk_i(clk), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .addr_i(addr_i), .data_i(data_i), .data_o(d15), .stall_o(stall15), .err_o(e15));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
`ifdef DMEM_ADDR_CHECK_EN
    return (a[1:0] != 0) || (a[31:10] != 0);
`else
    return (a == a) ? 1'b0 : 1'b0;
`endif
  endfunction

  // Called at the start of the request cycle (just after a rising edge); returns at the start of the following IDLE cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int i = int'(a[9:2]);
    bit b = is_bad(a);
    MemRead_i = rd; MemWrite_i = wr; addr_i = a; data_i = d;
    for (int k = 0; k <= LAT; k++) begin
      @(negedge clk);
      check("stall_busy", {31'b0, stall_o}, 32'h1);
      @(posedge clk); #1;
    end
    if (wr) begin
      if (!b) model[i] = d;
    end else exp_data = b ? 32'h0 : model[i];
`ifdef DMEM_ADDR_CHECK_EN
    exp_err = b;
`endif
    MemRead_i = 0; MemWrite_i = 0;
    @(negedge clk);
    check("stall_done", {31'b0, stall_o}, 32'h0);
    check("data_done", data_o, exp_data);
    check("err_done", {31'b0, err_o}, {31'b0, exp_err});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 0;
    repeat (2) @(posedge clk);
    #1 rst_i = 1;
    exp_data = 0; exp_err = 0;
  endtask

  initial begin
    int n2, n1, n15;
    bit f2, f1, f15;
    logic [31:0] a;
    do_reset();
    repeat (3) begin
      @(negedge clk);
      check("idle_stall", {31'b0, stall_o}, 32'h0);
      check("idle_data", data_o, 32'h0);
      check("idle_err", {31'b0, err_o}, 32'h0);
      @(posedge clk); #1;
    end
    n2 = 0; n1 = 0; n15 = 0; f2 = 0; f1 = 0; f15 = 0;
    MemRead_i = 1; addr_i = 0;
    repeat (20) begin
      @(negedge clk);
      if (!f2) begin if (stall_o) n2++; else f2 = 1; end
      if (!f1) begin if (stall1) n1++; else f1 = 1; end
      if (!f15) begin if (stall15) n15++; else f15 = 1; end
      @(posedge clk); #1;
    end
    MemRead_i = 0;
    check("stall_len_lat2", n2, 3);
    check("stall_len_lat1", n1, 2);
    check("stall_len_lat15", n15, 16);
    repeat (20) @(posedge clk);
    #1 do_reset();
    for (int i = 0; i < 17; i++) access(0, 1, i << 2, $urandom);
    access(0, 1, 32'h10, 32'hDEADBEEF);
    access(1, 0, 32'h10, 0);
    check("rd_deadbeef", data_o, 32'hDEADBEEF);
    access(1, 1, 32'h20, 32'h5);
    check("both_keeps_data", data_o, 32'hDEADBEEF);
    access(1, 0, 32'h20, 0);
    check("rd_both_result", data_o, 32'h5);
    access(0, 1, 32'h40, 32'hAAAA5555);
    MemWrite_i = 1; addr_i = 32'h40; data_i = 32'h1234;
    @(negedge clk);
    check("rst_req_stall", {31'b0, stall_o}, 32'h1);
    @(posedge clk); #1;
    rst_i = 0; MemWrite_i = 0;
    @(negedge clk);
    check("rst_busy_stall", {31'b0, stall_o}, 32'h1);
    @(posedge clk); #1;
    rst_i = 1; exp_data = 0; exp_err = 0;
    @(negedge clk);
    check("rst_idle_stall", {31'b0, stall_o}, 32'h0);
    check("rst_data_clr", data_o, 32'h0);
    check("rst_err_clr", {31'b0, err_o}, 32'h0);
    @(posedge clk); #1;
    access(1, 0, 32'h40, 0);
    check("rst_dropped_wr", data_o, 32'hAAAA5555);
`ifdef DMEM_ADDR_CHECK_EN
    access(1, 0, 32'h13, 0);
    check("misaligned_err", {31'b0, err_o}, 32'h1);
    check("misaligned_data", data_o, 32'h0);
    access(1, 0, 32'h10, 0);
    check("err_cleared", {31'b0, err_o}, 32'h0);
`else
    access(0, 1, 32'h400, 32'hCAFEF00D);
    access(1, 0, 32'h0, 0);
    check("alias_0x400", data_o, 32'hCAFEF00D);
`endif
    for (int t = 0; t < 40; t++) begin
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC03);
      case ($urandom_range(0, 2))
        0: access(1, 0, a, 0);
        1: access(0, 1, a, $urandom);
        default: access(1, 1, a, $urandom);
      endcase
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end
endmodule
